rtc_bus_sched: RTL

RTC_BUS_SCHED -- requirements
Module: rtc_bus_sched

---
 rtl/rtc_bus_sched_if.sv | 43 ++++
 rtl/rtc_bus_sched.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sched_if.sv
// rtc_bus_sched_if: groups the keyboard-write handshake, refresh request, RTC strobes,
// multiplexed address/data bus and read-result signals of the RTC bus scheduler.
//   master : scheduler side (drives strobes, bus, kb_ack, rd_*, busy)
//   slave  : environment side (keyboard, refresh source, RTC device, read consumer)
// With RTC_SCHED_OVR_EN defined the sticky ignored-refresh flag ovr is also carried.
interface rtc_bus_sched_if;
    logic       kb_req;
    logic [3:0] kb_addr;
    logic [7:0] kb_data;
    logic       kb_ack;
    logic       refresh_tick;
    logic       bus_cs_n;
    logic       bus_rd_n;
    logic       bus_wr_n;
    logic [7:0] bus_ad_out;
    logic       bus_ad_oe;
    logic [7:0] bus_ad_in;
    logic       rd_valid;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
`ifdef RTC_SCHED_OVR_EN
    logic       ovr;
`endif

    modport master (
`ifdef RTC_SCHED_OVR_EN
        output ovr,
`endif
        input  kb_req, kb_addr, kb_data, refresh_tick, bus_ad_in,
        output kb_ack, bus_cs_n, bus_rd_n, bus_wr_n, bus_ad_out, bus_ad_oe,
        output rd_valid, rd_addr, rd_data, busy
    );

    modport slave (
`ifdef RTC_SCHED_OVR_EN
        input  ovr,
`endif
        output kb_req, kb_addr, kb_data, refresh_tick, bus_ad_in,
        input  kb_ack, bus_cs_n, bus_rd_n, bus_wr_n, bus_ad_out, bus_ad_oe,
        input  rd_valid, rd_addr, rd_data, busy
    );
endinterface

// File: rtl/rtc_bus_sched.sv
// rtc_bus_sched: arbitrates between keyboard register writes and a periodic read sweep of
// the RTC registers, and runs each transaction on a multiplexed, active-low-strobed bus as
// IDLE -> ADDR (PHASE_CYC) -> DATA (PHASE_CYC) -> RECOVER (1) -> IDLE.
// Ports:
//   CLK     : clock, rising edge
//   RESET   : asynchronous, active-high reset; aborts any transaction silently
//   ctrl_io : rtc_bus_sched_if.master (keyboard handshake, refresh_tick, RTC bus, read result)
// Optional feature: define RTC_SCHED_OVR_EN to add the sticky ovr flag, set whenever a
// refresh_tick arrives while a sweep is still pending.
module rtc_bus_sched #(
    parameter int unsigned PHASE_CYC = 4,
    parameter int unsigned NUM_REGS  = 12
) (
    input logic          CLK,
    input logic          RESET,
    rtc_bus_sched_if.master ctrl_io
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StAddr    = 2'd1;
    localparam logic [1:0] StData    = 2'd2;
    localparam logic [1:0] StRecover = 2'd3;

    localparam logic [3:0] LastPhase = 4'(PHASE_CYC - 1);
    localparam logic [3:0] LastIdx   = 4'(NUM_REGS - 1);
    localparam logic [4:0] NumRegs   = 5'(NUM_REGS);

    logic [1:0] state_q, state_d;
    logic [3:0] phase_q, phase_d;
    logic       is_wr_q, is_wr_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       pending_q, pending_d;
    logic [3:0] sweep_idx_q, sweep_idx_d;
    logic [3:0] rd_addr_q, rd_addr_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       last_phase;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        is_wr_d     = is_wr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        pending_d   = pending_q;
        sweep_idx_d = sweep_idx_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        last_phase  = (phase_q == LastPhase);

        // A tick only starts a sweep when none is pending; pending is still set during the
        // RECOVER of the final read, so a tick in that cycle is dropped as well.
        if (ctrl_io.refresh_tick && !pending_q) begin
            pending_d   = 1'b1;
            sweep_idx_d = 4'd0;
        end

        case (state_q)
            StIdle: begin
                phase_d = 4'd0;
                if (ctrl_io.kb_req) begin
                    is_wr_d = 1'b1;
                    addr_d  = ctrl_io.kb_addr;
                    data_d  = ctrl_io.kb_data;
                    // Out-of-range writes are acknowledged without touching the bus.
                    state_d = ({1'b0, ctrl_io.kb_addr} >= NumRegs) ? StRecover : StAddr;
                end else if (pending_q) begin
                    is_wr_d = 1'b0;
                    addr_d  = sweep_idx_q;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (last_phase) begin
                    phase_d = 4'd0;
                    state_d = StData;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StData: begin
                if (last_phase) begin
                    phase_d = 4'd0;
                    state_d = StRecover;
                    if (!is_wr_q) begin
                        rd_addr_d = addr_q;
                        rd_data_d = ctrl_io.bus_ad_in;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            StRecover: begin
                state_d = StIdle;
                if (!is_wr_q) begin
                    sweep_idx_d = sweep_idx_q + 4'd1;
                    if (sweep_idx_q == LastIdx) begin
                        pending_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= StIdle;
            phase_q     <= 4'd0;
            is_wr_q     <= 1'b0;
            addr_q      <= 4'd0;
            data_q      <= 8'd0;
            pending_q   <= 1'b0;
            sweep_idx_q <= 4'd0;
            rd_addr_q   <= 4'd0;
            rd_data_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            is_wr_q     <= is_wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            pending_q   <= pending_d;
            sweep_idx_q <= sweep_idx_d;
            rd_addr_q   <= rd_addr_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Strobes decode straight from state so an asynchronous reset releases the bus at once.
    always_comb begin
        ctrl_io.bus_cs_n   = 1'b1;
        ctrl_io.bus_rd_n   = 1'b1;
        ctrl_io.bus_wr_n   = 1'b1;
        ctrl_io.bus_ad_oe  = 1'b0;
        ctrl_io.bus_ad_out = 8'h00;
        case (state_q)
            StAddr: begin
                ctrl_io.bus_cs_n   = 1'b0;
                ctrl_io.bus_ad_oe  = 1'b1;
                ctrl_io.bus_ad_out = {4'h0, addr_q};
            end
            StData: begin
                ctrl_io.bus_cs_n = 1'b0;
                if (is_wr_q) begin
                    ctrl_io.bus_wr_n   = 1'b0;
                    ctrl_io.bus_ad_oe  = 1'b1;
                    ctrl_io.bus_ad_out = data_q;
                end else begin
                    ctrl_io.bus_rd_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign ctrl_io.kb_ack   = (state_q == StRecover) && is_wr_q;
    assign ctrl_io.rd_valid = (state_q == StRecover) && !is_wr_q;
    assign ctrl_io.rd_addr  = rd_addr_q;
    assign ctrl_io.rd_data  = rd_data_q;
    assign ctrl_io.busy     = (state_q != StIdle);

`ifdef RTC_SCHED_OVR_EN
    logic ovr_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ovr_q <= 1'b0;
        end else if (ctrl_io.refresh_tick && pending_q) begin
            ovr_q <= 1'b1;
        end
    end

    assign ctrl_io.ovr = ovr_q;
`endif

endmodule
